pwm_peripheral: RTL and testbench

//  Consumes the five SPI-written control registers (output enables, PWM enables,

---
 rtl/pwm_pkg.sv | 47 ++++
 rtl/pwm_peripheral_if.sv | 44 ++++
 rtl/pwm_tick_gen.sv | 43 ++++
 rtl/pwm_peripheral.sv | 92 +++++++++
 tb/tb_pwm_peripheral.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared constants, types and helpers for the 16-channel PWM peripheral.
//   PWM_BITS        width of the PWM counter and duty value
//   N_CH            number of output pins
//   DUTY_FULL       duty code that means "always high" (not 255/256)
//   CLK_DIV_DEFAULT clk cycles per PWM count step
// ---------------------------------------------------------------------------
package pwm_pkg;

    localparam int PWM_BITS        = 8;
    localparam int N_CH            = 16;
    localparam int CLK_DIV_DEFAULT = 13;

    typedef logic [PWM_BITS-1:0] pwm_cnt_t;
    typedef logic [N_CH-1:0]     ch_vec_t;

    localparam pwm_cnt_t DUTY_FULL = 8'hFF;
    localparam pwm_cnt_t CNT_LAST  = 8'hFF;

    // Shared waveform level. Full-scale duty is special-cased to a solid high
    // so that 0xFF really means 100 % rather than 255/256.
    function automatic logic pwm_compare(input pwm_cnt_t cnt, input pwm_cnt_t duty);
        logic hi;
        if (duty == DUTY_FULL) begin
            hi = 1'b1;
        end else begin
            hi = (cnt < duty);
        end
        return hi;
    endfunction

    // Per-pin select: disabled pins are forced low and win over PWM select.
    function automatic logic pin_select(input logic en_out, input logic en_pwm,
                                        input logic pwm_hi);
        logic pin;
        if (!en_out) begin
            pin = 1'b0;
        end else if (en_pwm) begin
            pin = pwm_hi;
        end else begin
            pin = 1'b1;
        end
        return pin;
    endfunction

endpackage

// File: rtl/pwm_peripheral_if.sv
// ---------------------------------------------------------------------------
// pwm_peripheral_if
// Bundles the control-register inputs and the pin outputs of the PWM
// peripheral.
//   en_reg_out_7_0 / en_reg_out_15_8  output enable per pin (1 = driven)
//   en_reg_pwm_7_0 / en_reg_pwm_15_8  PWM select per pin (1 = PWM, 0 = high)
//   pwm_duty_cycle                    shared duty value
//   out                               registered pin outputs
//   period_start                      1-cycle pulse when the PWM counter wraps
// modport master : register block side (drives the controls)
// modport slave  : PWM peripheral side
// ---------------------------------------------------------------------------
interface pwm_peripheral_if;
    import pwm_pkg::*;

    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    pwm_cnt_t   pwm_duty_cycle;
    ch_vec_t    out;
    logic       period_start;

    modport master (
        output en_reg_out_7_0,
        output en_reg_out_15_8,
        output en_reg_pwm_7_0,
        output en_reg_pwm_15_8,
        output pwm_duty_cycle,
        input  out,
        input  period_start
    );

    modport slave (
        input  en_reg_out_7_0,
        input  en_reg_out_15_8,
        input  en_reg_pwm_7_0,
        input  en_reg_pwm_15_8,
        input  pwm_duty_cycle,
        output out,
        output period_start
    );

endinterface

// File: rtl/pwm_tick_gen.sv
// ---------------------------------------------------------------------------
// pwm_tick_gen
// Prescaler for the PWM counter: div_cnt runs 0..CLK_DIV-1 and tick_o is
// high for the one clk where div_cnt sits at CLK_DIV-1. With CLK_DIV=1 the
// tick is asserted every clk.
//   clk     system clock
//   rst_n   asynchronous active-low reset (div_cnt -> 0)
//   tick_o  count-enable for the PWM counter
// ---------------------------------------------------------------------------
module pwm_tick_gen
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    always_comb begin
        tick_o    = (div_cnt_q == DIV_LAST);
        div_cnt_d = div_cnt_q + DIV_ONE;
        if (tick_o) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/pwm_peripheral.sv
// ---------------------------------------------------------------------------
// pwm_peripheral
// Drives 16 pins from the SPI control registers. Each pin is forced low,
// held static high, or follows one shared 8-bit PWM waveform whose period is
// 256*CLK_DIV clk cycles.
//   clk    system clock, everything on posedge
//   rst_n  asynchronous active-low reset
//   bus    pwm_peripheral_if.slave: enable/select/duty in, out/period_start out
//
// The duty value is shadowed into duty_q only when the counter wraps, so a
// mid-period write never produces a runt pulse. Enables and PWM selects are
// used live and reach the pins one clk later through the output register.
// After reset duty_q is 0, so the first period is all-low on PWM pins.
// ---------------------------------------------------------------------------
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    pwm_peripheral_if.slave   bus
);

    logic     tick;
    logic     wrap;
    logic     pwm_hi;
    ch_vec_t  en_out;
    ch_vec_t  en_pwm;

    pwm_cnt_t pwm_cnt_q;
    pwm_cnt_t pwm_cnt_d;
    pwm_cnt_t duty_q;
    pwm_cnt_t duty_d;
    ch_vec_t  out_q;
    ch_vec_t  out_d;
    logic     period_start_q;
    logic     period_start_d;

    pwm_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

    // Counter, wrap detect and duty shadow.
    always_comb begin
        wrap           = tick && (pwm_cnt_q == CNT_LAST);
        pwm_cnt_d      = pwm_cnt_q;
        duty_d         = duty_q;
        period_start_d = wrap;
        if (tick) begin
            pwm_cnt_d = pwm_cnt_q + 8'd1;
        end
        // A duty write landing on the wrap clk is captured by this wrap.
        if (wrap) begin
            duty_d = bus.pwm_duty_cycle;
        end
    end

    // Comparator and per-pin output mux.
    always_comb begin
        pwm_hi = pwm_compare(pwm_cnt_q, duty_q);
        out_d  = '0;
        for (int i = 0; i < N_CH; i++) begin
            out_d[i] = pin_select(en_out[i], en_pwm[i], pwm_hi);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q      <= '0;
            duty_q         <= '0;
            out_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            pwm_cnt_q      <= pwm_cnt_d;
            duty_q         <= duty_d;
            out_q          <= out_d;
            period_start_q <= period_start_d;
        end
    end

    assign bus.out          = out_q;
    assign bus.period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
module tb_pwm_peripheral;

    localparam int CLK_DIV = 13;
    localparam int PERIOD  = 256 * CLK_DIV;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    pwm_peripheral_if bus ();

    pwm_peripheral #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] en_out;
        logic [15:0] en_pwm;
        logic [7:0]  duty;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_regs(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        bus.en_reg_out_7_0  = eo[7:0];
        bus.en_reg_out_15_8 = eo[15:8];
        bus.en_reg_pwm_7_0  = ep[7:0];
        bus.en_reg_pwm_15_8 = ep[15:8];
        bus.pwm_duty_cycle  = d;
    endtask

    task automatic wait_pstart(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.period_start && n < limit);
        if (!bus.period_start) chk("period_start_timeout", 32'd0, 32'd1);
    endtask

    // Counts consecutive samples equal to v; the current sample is number 'start'.
    task automatic measure_run(input logic [15:0] v, input int start, output int n);
        n = start;
        forever begin
            @(negedge clk);
            if (bus.out !== v || n >= 8000) break;
            n++;
        end
    endtask

    initial begin
        int n;
        int m;
        int bad;

        n_pass  = 0;
        n_total = 0;

        vecs[0] = '{16'hFFFF, 16'h0000, 8'h80, 16'hFFFF};
        vecs[1] = '{16'h00FF, 16'h0000, 8'h80, 16'h00FF};
        vecs[2] = '{16'hFFFF, 16'h00FF, 8'h80, 16'hFF00};
        vecs[3] = '{16'h0000, 16'hFFFF, 8'hFF, 16'h0000};
        vecs[4] = '{16'hA5A5, 16'h0F0F, 8'h40, 16'hA0A0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 8'hFF, 16'h0000};
        vecs[6] = '{16'h1234, 16'h0004, 8'h00, 16'h1230};

        // Reset held with everything enabled.
        rst_n = 1'b0;
        set_regs(16'hFFFF, 16'hFFFF, 8'h80);
        repeat (4) @(negedge clk);
        chk("reset_out", 32'(bus.out), 32'h0);
        chk("reset_pstart", 32'(bus.period_start), 32'h0);
        rst_n = 1'b1;

        // Static vectors in the first period (duty_q still 0 -> PWM pins low).
        for (int i = 0; i < 7; i++) begin
            set_regs(vecs[i].en_out, vecs[i].en_pwm, vecs[i].duty);
            @(negedge clk);
            chk($sformatf("vec%0d_out", i), 32'(bus.out), 32'(vecs[i].exp_out));
            chk($sformatf("vec%0d_pstart", i), 32'(bus.period_start), 32'h0);
        end

        // 50 % duty: period, edge latency and high/low durations.
        set_regs(16'hFFFF, 16'hFFFF, 8'h80);
        wait_pstart(2 * PERIOD, n);
        wait_pstart(2 * PERIOD, n);
        chk("period_len", 32'(n), 32'(PERIOD));
        chk("d80_out_at_pstart", 32'(bus.out), 32'h0);
        @(negedge clk);
        chk("d80_rise_after_pstart", 32'(bus.out), 32'hFFFF);
        chk("pstart_one_cycle", 32'(bus.period_start), 32'h0);
        measure_run(16'hFFFF, 1, n);
        chk("d80_high_len", 32'(n), 32'd1664);
        measure_run(16'h0000, 1, n);
        chk("d80_low_len", 32'(n), 32'd1664);

        // Duty 0x00 -> constantly low over three periods.
        set_regs(16'hFFFF, 16'hFFFF, 8'h00);
        wait_pstart(2 * PERIOD, n);
        bad = 0;
        repeat (3 * PERIOD) begin
            @(negedge clk);
            if (bus.out !== 16'h0000) bad++;
        end
        chk("d00_const_low", 32'(bad), 32'd0);

        // Duty 0xFF -> constantly high over three periods.
        set_regs(16'hFFFF, 16'hFFFF, 8'hFF);
        wait_pstart(2 * PERIOD, n);
        bad = 0;
        repeat (3 * PERIOD) begin
            @(negedge clk);
            if (bus.out !== 16'hFFFF) bad++;
        end
        chk("dFF_const_high", 32'(bad), 32'd0);

        // Mid-period duty change 0x40 -> 0xC0 is deferred to the next period.
        set_regs(16'hFFFF, 16'hFFFF, 8'h40);
        wait_pstart(2 * PERIOD, n);
        repeat (101) @(negedge clk);
        chk("d40_high_mid", 32'(bus.out), 32'hFFFF);
        set_regs(16'hFFFF, 16'hFFFF, 8'hC0);
        measure_run(16'hFFFF, 101, n);
        chk("d40_high_len", 32'(n), 32'd832);
        measure_run(16'h0000, 1, n);
        chk("d40_low_len", 32'(n), 32'd2496);
        measure_run(16'hFFFF, 1, n);
        chk("dC0_high_len", 32'(n), 32'd2496);

        // Async reset mid-period at pwm_cnt=100.
        set_regs(16'hFFFF, 16'hFFFF, 8'h80);
        wait_pstart(2 * PERIOD, n);
        repeat (1300) @(negedge clk);
        chk("pre_reset_high", 32'(bus.out), 32'hFFFF);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_out", 32'(bus.out), 32'h0);
        chk("async_reset_pstart", 32'(bus.period_start), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        bad = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.out !== 16'h0000) bad++;
        end while (!bus.period_start && n < 2 * PERIOD);
        chk("post_reset_first_period_len", 32'(n), 32'(PERIOD));
        chk("post_reset_first_period_low", 32'(bad), 32'd0);
        @(negedge clk);
        chk("post_reset_second_rise", 32'(bus.out), 32'hFFFF);
        measure_run(16'hFFFF, 1, m);
        chk("post_reset_second_high_len", 32'(m), 32'd1664);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
